// File: rtl/ball_pkg.sv
// Shared constants and types for the ball motion controller.
package ball_pkg;

  // Bit positions inside the 4-bit movement request {RIGHT,LEFT,DOWN,UP}
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  // Map pixel codes; anything else is walkable floor
  localparam logic [7:0] PX_WALL = 8'h26;
  localparam logic [7:0] PX_HOLE = 8'h49;
  localparam logic [7:0] PX_WIN  = 8'hF9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_X,
    ST_SCAN_Y,
    ST_COMMIT,
    ST_WON,
    ST_DEAD
  } state_t;

  typedef enum logic [1:0] {
    RES_FLOOR,
    RES_WALL,
    RES_HOLE,
    RES_WIN
  } res_t;

  function automatic res_t classify(input logic [7:0] px);
    case (px)
      PX_WALL: return RES_WALL;
      PX_HOLE: return RES_HOLE;
      PX_WIN:  return RES_WIN;
      default: return RES_FLOOR;
    endcase
  endfunction

endpackage

// File: rtl/edge_scanner.sv
// Walks the 2*RADIUS-1 pixels of one leading edge of the ball, one map
// read at a time, and reports the first non-floor pixel (or FLOOR).
module edge_scanner
  import ball_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int RADIUS      = 8,
  parameter int MAP_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               axis_y,
  input  logic               neg,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [7:0]         map_data,
  output logic               map_rd,
  output logic [COORD_W-1:0] col_addr,
  output logic [COORD_W-1:0] row_addr,
  output logic               done,
  output res_t               result
);

  localparam int SPAN  = 2*RADIUS-1;
  localparam int IDX_W = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int LAT_W = $clog2(MAP_LATENCY+1);

  // One extra bit so edges past either border show up as a set MSB
  typedef logic signed [COORD_W:0] saddr_t;
  localparam saddr_t OFF     = saddr_t'(RADIUS);
  localparam saddr_t OFF_LAT = saddr_t'(RADIUS-1);

  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] lat;
  saddr_t base_e, base_l, edge_pos, lat_pos, col, row;
  logic   oor, issue, sample, last;
  res_t   px_res;

  // Address of the current edge pixel and read/sample timing
  always_comb begin
    base_e   = axis_y ? saddr_t'(y) : saddr_t'(x);
    base_l   = axis_y ? saddr_t'(x) : saddr_t'(y);
    edge_pos = neg ? base_e - OFF : base_e + OFF;
    lat_pos  = base_l - OFF_LAT + saddr_t'(idx);
    col      = axis_y ? lat_pos  : edge_pos;
    row      = axis_y ? edge_pos : lat_pos;
    oor      = col[COORD_W] | row[COORD_W];
    issue    = en & (lat == '0);
    sample   = en & (lat == LAT_W'(MAP_LATENCY));
    last     = (idx == IDX_W'(SPAN-1));
    map_rd   = issue & ~oor;
    col_addr = map_rd ? col[COORD_W-1:0] : '0;
    row_addr = map_rd ? row[COORD_W-1:0] : '0;
    px_res   = classify(map_data);
    // Off-map pixels end the scan as a wall without touching the map port
    done     = (issue & oor) | (sample & ((px_res != RES_FLOOR) | last));
    result   = (issue & oor) ? RES_WALL : px_res;
  end

  // Pixel index and read-latency counter; cleared between scans
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
      lat <= '0;
    end else if (!en || done) begin
      idx <= '0;
      lat <= '0;
    end else if (sample) begin
      idx <= idx + 1'b1;
      lat <= '0;
    end else begin
      lat <= lat + 1'b1;
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Multi-step ball controller: resolves X then Y per unit move against the
// external map, slides along walls, and handles holes, lives and winning.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int INITIAL_X   = 'h20F,
  parameter int INITIAL_Y   = 'hFE,
  parameter int WIN_X       = 'h13A,
  parameter int WIN_Y       = 'h30,
  parameter int RADIUS      = 8,
  parameter int STEP_W      = 2,
  parameter int MAP_LATENCY = 3,
  parameter int LIVES       = 3,
  parameter int LIVES_W     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         movement,
  input  logic [STEP_W-1:0]  step,
  output logic               map_rd,
  output logic [COORD_W-1:0] map_col_addr,
  output logic [COORD_W-1:0] map_row_addr,
  input  logic [7:0]         map_data,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               won_the_game,
  output logic               hit_a_hole,
  output logic [LIVES_W-1:0] lives_left,
  output logic               game_over
);

  state_t            state, state_nxt;
  logic [3:0]        mv_q;
  logic [STEP_W-1:0] step_q, count, count_inc;
  logic              moved;
  logic              in_net_x, in_net_y, accept;
  logic              net_x, net_y, neg_x, neg_y;
  logic              scan_en, scan_y, scan_done, last_life;
  res_t              scan_res;

  assign in_net_x  = movement[DIR_RIGHT] ^ movement[DIR_LEFT];
  assign in_net_y  = movement[DIR_DOWN]  ^ movement[DIR_UP];
  assign accept    = (state == ST_IDLE) && (step != '0) && (in_net_x || in_net_y);
  assign net_x     = mv_q[DIR_RIGHT] ^ mv_q[DIR_LEFT];
  assign net_y     = mv_q[DIR_DOWN]  ^ mv_q[DIR_UP];
  assign neg_x     = mv_q[DIR_LEFT];
  assign neg_y     = mv_q[DIR_UP];
  assign scan_en   = (state == ST_SCAN_X) || (state == ST_SCAN_Y);
  assign scan_y    = (state == ST_SCAN_Y);
  assign count_inc = count + 1'b1;
  assign last_life = (lives_left == LIVES_W'(1));
  assign busy      = accept || scan_en || (state == ST_COMMIT);

  edge_scanner #(
    .COORD_W    (COORD_W),
    .RADIUS     (RADIUS),
    .MAP_LATENCY(MAP_LATENCY)
  ) u_scan (
    .clk     (clk),
    .reset   (reset),
    .en      (scan_en),
    .axis_y  (scan_y),
    .neg     (scan_y ? neg_y : neg_x),
    .x       (x_out),
    .y       (y_out),
    .map_data(map_data),
    .map_rd  (map_rd),
    .col_addr(map_col_addr),
    .row_addr(map_row_addr),
    .done    (scan_done),
    .result  (scan_res)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: X scan, Y scan, commit per unit; hole/win cut the request short
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (accept) state_nxt = in_net_x ? ST_SCAN_X : ST_SCAN_Y;
      ST_SCAN_X, ST_SCAN_Y:
        if (scan_done) begin
          case (scan_res)
            RES_HOLE: state_nxt = last_life ? ST_DEAD : ST_IDLE;
            RES_WIN:  state_nxt = ST_WON;
            default:  state_nxt = (state == ST_SCAN_X && net_y) ? ST_SCAN_Y : ST_COMMIT;
          endcase
        end
      ST_COMMIT:
        // A unit where no axis moved means every further unit would stall too
        if (count_inc == step_q || !moved) state_nxt = ST_IDLE;
        else                                state_nxt = net_x ? ST_SCAN_X : ST_SCAN_Y;
      default: state_nxt = state;
    endcase
  end

  // Position, request latch, unit counter, lives and game flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out        <= COORD_W'(INITIAL_X);
      y_out        <= COORD_W'(INITIAL_Y);
      mv_q         <= '0;
      step_q       <= '0;
      count        <= '0;
      moved        <= 1'b0;
      lives_left   <= LIVES_W'(LIVES);
      won_the_game <= 1'b0;
      hit_a_hole   <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      hit_a_hole <= 1'b0;
      case (state)
        ST_IDLE:
          if (accept) begin
            mv_q   <= movement;
            step_q <= step;
            count  <= '0;
            moved  <= 1'b0;
          end
        ST_SCAN_X, ST_SCAN_Y:
          if (scan_done) begin
            case (scan_res)
              RES_FLOOR: begin
                moved <= 1'b1;
                if (scan_y) y_out <= neg_y ? y_out - 1'b1 : y_out + 1'b1;
                else        x_out <= neg_x ? x_out - 1'b1 : x_out + 1'b1;
              end
              RES_HOLE: begin
                x_out      <= COORD_W'(INITIAL_X);
                y_out      <= COORD_W'(INITIAL_Y);
                lives_left <= lives_left - 1'b1;
                hit_a_hole <= 1'b1;
                if (last_life) game_over <= 1'b1;
              end
              RES_WIN: begin
                x_out        <= COORD_W'(WIN_X);
                y_out        <= COORD_W'(WIN_Y);
                won_the_game <= 1'b1;
              end
              default: ;
            endcase
          end
        ST_COMMIT: begin
          count <= count_inc;
          moved <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Randomized + directed bench for ball_motion_ctrl with a behavioural map ROM
// and a loop-level reference model of whole requests.
module tb_ball_motion_ctrl;

  localparam int CW = 10, R = 8, LAT = 3;
  localparam int IX = 527, IY = 254, WX = 314, WY = 48;
  localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;
  localparam logic [7:0] C_WALL = 8'h26, C_HOLE = 8'h49, C_WIN = 8'hF9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    movement = '0;
  logic [1:0]    step = '0;
  logic          map_rd;
  logic [CW-1:0] map_col_addr, map_row_addr, x_out, y_out;
  logic [7:0]    map_data;
  logic          busy, won_the_game, hit_a_hole, game_over;
  logic [1:0]    lives_left;

  ball_motion_ctrl dut (
    .clk         (clk),
    .reset       (rst),
    .movement    (movement),
    .step        (step),
    .map_rd      (map_rd),
    .map_col_addr(map_col_addr),
    .map_row_addr(map_row_addr),
    .map_data    (map_data),
    .x_out       (x_out),
    .y_out       (y_out),
    .busy        (busy),
    .won_the_game(won_the_game),
    .hit_a_hole  (hit_a_hole),
    .lives_left  (lives_left),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  // Sparse map: only non-floor pixels are stored
  logic [7:0] scene [int];
  function automatic logic [7:0] px(input int c, input int r);
    if (scene.exists(c*1024 + r)) return scene[c*1024 + r];
    return 8'h00;
  endfunction

  // Map ROM with LAT cycles of read latency
  logic [7:0] rom_req;
  logic [7:0] rom_pipe [0:LAT-1];
  always @(negedge clk) rom_req = map_rd ? px(int'(map_col_addr), int'(map_row_addr)) : 8'h00;
  always @(posedge clk) begin
    rom_pipe[0] <= rom_req;
    for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign map_data = rom_pipe[LAT-1];

  // Activity monitor: busy cycles, reads (checked against expected addresses), hole pulses
  int n_busy, n_rd, n_hit, addr_err;
  logic [19:0] exp_q [$];
  always @(negedge clk) if (!rst) begin
    if (busy) n_busy++;
    if (map_rd) begin
      n_rd++;
      if (exp_q.size() == 0) addr_err++;
      else begin
        if (exp_q[0] !== {map_col_addr, map_row_addr}) addr_err++;
        exp_q.delete(0);
      end
    end
    if (hit_a_hole) n_hit++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model state
  int mx, my, ml, e_busy, e_rd, e_hit;
  bit mwon, mover;

  // Whole-request model: per unit, scan X edge then Y edge pixel by pixel
  task automatic model_req(input logic [3:0] mv, input int st);
    int hx, vy, d, c, r, res;
    logic [7:0] code;
    bit moved;
    e_busy = 0; e_rd = 0; e_hit = 0;
    hx = int'(mv[3]) - int'(mv[2]);
    vy = int'(mv[1]) - int'(mv[0]);
    if (mwon || mover || st == 0 || (hx == 0 && vy == 0)) return;
    e_busy = 1;
    for (int u = 0; u < st; u++) begin
      moved = 0;
      for (int ax = 0; ax < 2; ax++) begin
        d = (ax == 0) ? hx : vy;
        if (d == 0) continue;
        res = 0;
        for (int k = 0; k < 2*R-1; k++) begin
          if (ax == 0) begin c = mx + d*R; r = my - R + 1 + k; end
          else         begin c = mx - R + 1 + k; r = my + d*R; end
          if (c < 0 || c >= 1024 || r < 0 || r >= 1024) begin res = 1; e_busy += 1; break; end
          exp_q.push_back({c[9:0], r[9:0]});
          e_rd++;
          e_busy += LAT + 1;
          code = px(c, r);
          if (code == C_WALL) begin res = 1; break; end
          if (code == C_HOLE) begin res = 2; break; end
          if (code == C_WIN)  begin res = 3; break; end
        end
        if (res == 0) begin
          moved = 1;
          if (ax == 0) mx += d; else my += d;
        end else if (res == 2) begin
          mx = IX; my = IY; ml--; e_hit = 1;
          if (ml == 0) mover = 1;
          return;
        end else if (res == 3) begin
          mx = WX; my = WY; mwon = 1;
          return;
        end
      end
      e_busy += 1;
      if (!moved) return;
    end
  endtask

  task automatic check_req(input string tag);
    chk({tag, ".x"},     int'(x_out), mx);
    chk({tag, ".y"},     int'(y_out), my);
    chk({tag, ".lives"}, int'(lives_left), ml);
    chk({tag, ".won"},   int'(won_the_game), int'(mwon));
    chk({tag, ".over"},  int'(game_over), int'(mover));
    chk({tag, ".reads"}, n_rd, e_rd);
    chk({tag, ".busy"},  n_busy, e_busy);
    chk({tag, ".hits"},  n_hit, e_hit);
    chk({tag, ".addr"},  addr_err, 0);
    chk({tag, ".left"},  exp_q.size(), 0);
  endtask

  task automatic req(input logic [3:0] mv, input int st, input string tag);
    int guard;
    model_req(mv, st);
    @(posedge clk); #1;
    n_busy = 0; n_rd = 0; n_hit = 0; addr_err = 0;
    movement = mv; step = st[1:0];
    @(posedge clk); #1;
    movement = '0; step = '0;
    guard = 0;
    while (busy && guard < 5000) begin @(negedge clk); guard++; end
    chk({tag, ".timeout"}, int'(guard < 5000), 1);
    repeat (3) @(negedge clk);
    check_req(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; movement = '0; step = '0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    scene.delete();
    n_busy = 0; n_rd = 0; n_hit = 0; addr_err = 0;
    mx = IX; my = IY; ml = 3; mwon = 0; mover = 0;
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.x", int'(x_out), IX);
    chk("rst.y", int'(y_out), IY);
    chk("rst.lives", int'(lives_left), 3);
    chk("rst.flags", int'({won_the_game, hit_a_hole, game_over, busy}), 0);
    chk("rst.rd", int'(map_rd), 0);
    chk("rst.addr", int'({map_col_addr, map_row_addr}), 0);

    // Open floor, RIGHT step 3
    do_reset();
    req(RIGHT, 3, "open");
    chk("open.x530", int'(x_out), 530);
    chk("open.cyc184", n_busy, 184);
    chk("open.rd45", n_rd, 45);

    // Wall one pixel beyond the first edge
    do_reset();
    scene[536*1024 + 254] = C_WALL;
    req(RIGHT, 3, "wall");
    chk("wall.x528", int'(x_out), 528);

    // Diagonal slide along a right-hand wall
    do_reset();
    scene[535*1024 + 254] = C_WALL;
    req(UP | RIGHT, 2, "slide");
    chk("slide.x", int'(x_out), 527);
    chk("slide.y252", int'(y_out), 252);

    // Three holes end the game; later requests do nothing
    do_reset();
    scene[527*1024 + 262] = C_HOLE;
    req(DOWN, 1, "hole1");
    chk("hole1.lives2", int'(lives_left), 2);
    req(DOWN, 2, "hole2");
    req(DOWN, 3, "hole3");
    chk("hole3.over", int'(game_over), 1);
    req(RIGHT, 3, "dead");
    chk("dead.rd0", n_rd, 0);

    // Win pixel mid-scan, then movement ignored
    do_reset();
    scene[535*1024 + 254] = C_WIN;
    req(RIGHT, 3, "win");
    chk("win.x314", int'(x_out), 314);
    chk("win.y48", int'(y_out), 48);
    req(LEFT, 2, "won");

    // Net-zero request
    do_reset();
    req(UP | DOWN, 3, "updown");
    chk("updown.busy0", n_busy, 0);

    // Async reset in the middle of a scan
    do_reset();
    req(RIGHT, 1, "pre");
    @(posedge clk); #1; movement = RIGHT; step = 2'd3;
    @(posedge clk); #1; movement = '0; step = '0;
    repeat (8) @(posedge clk); #1;
    chk("mid.rd_before", int'(map_rd), 1);
    #1 rst = 1'b1;
    #1;
    chk("mid.x", int'(x_out), IX);
    chk("mid.y", int'(y_out), IY);
    chk("mid.rd", int'(map_rd), 0);
    chk("mid.busy", int'(busy), 0);

    // Walk to the left border: the last in-range edge is column 0
    do_reset();
    for (int i = 0; i < 200 && mx > 7; i++) req(LEFT, 3, "walk");
    chk("walk.x7", int'(x_out), 7);
    req(LEFT, 3, "border");
    chk("border.rd0", n_rd, 0);
    chk("border.x7", int'(x_out), 7);

    // Random maps around spawn with random requests
    for (int rnd = 0; rnd < 3; rnd++) begin
      do_reset();
      for (int p = 0; p < 80; p++) begin
        int c, r, w;
        c = 480 + int'($urandom_range(0, 100));
        r = 200 + int'($urandom_range(0, 110));
        w = int'($urandom_range(0, 19));
        scene[c*1024 + r] = (w < 15) ? C_WALL : (w < 19) ? C_HOLE : C_WIN;
      end
      for (int n = 0; n < 30; n++)
        req(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
